// File: rtl/multiplexor_4a1_rr.sv
// Four-channel valid/ready round-robin multiplexor onto one registered output channel.
// Each output word is tagged with its source's demultiplexor selector code.
module multiplexor_4a1_rr #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    input  logic [ANCHO-1:0] C,
    input  logic [ANCHO-1:0] D,
    input  logic [3:0]       Valido,
    output logic [3:0]       Listo,
    output logic [ANCHO-1:0] X,
    output logic [2:0]       Selector,
    output logic             ValidoX,
    input  logic             ListoX
);

    typedef enum logic {VACIO, LLENO} estado_t;

    estado_t          estado;
    logic [1:0]       ultimo;
    logic             puede;
    logic             captura;
    logic [1:0]       gidx;
    logic [1:0]       idx;
    logic [ANCHO-1:0] dato;

    assign puede = (estado == VACIO) || ListoX;

    // Search starts one past the last grant, so the previous winner ranks last.
    always_comb begin
        Listo   = '0;
        captura = 1'b0;
        gidx    = '0;
        idx     = '0;
        if (!rst && puede) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                idx = ultimo + 2'(k);
                if (!captura && Valido[idx]) begin
                    Listo[idx] = 1'b1;
                    gidx       = idx;
                    captura    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        dato = '0;
        case (gidx)
            2'd0: dato = A;
            2'd1: dato = B;
            2'd2: dato = C;
            2'd3: dato = D;
            default: dato = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= VACIO;
            ValidoX  <= 1'b0;
            X        <= '0;
            Selector <= '0;
            ultimo   <= 2'd3;
        end else begin
            case (estado)
                VACIO: begin
                    if (captura) begin
                        estado   <= LLENO;
                        ValidoX  <= 1'b1;
                        X        <= dato;
                        Selector <= 3'(gidx) + 3'd1;
                        ultimo   <= gidx;
                    end
                end
                LLENO: begin
                    if (ListoX) begin
                        if (captura) begin
                            X        <= dato;
                            Selector <= 3'(gidx) + 3'd1;
                            ultimo   <= gidx;
                        end else begin
                            estado  <= VACIO;
                            ValidoX <= 1'b0;
                        end
                    end
                end
                default: begin
                    estado  <= VACIO;
                    ValidoX <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplexor_4a1_rr.sv
// Directed bench for multiplexor_4a1_rr: reset, single channel, fairness,
// backpressure, drain-and-capture and mid-transfer reset.
module tb_multiplexor_4a1_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B, C, D;
    logic [3:0] Valido;
    logic [3:0] Listo;
    logic [3:0] X;
    logic [2:0] Selector;
    logic       ValidoX;
    logic       ListoX;

    int checks = 0;
    int passes = 0;

    multiplexor_4a1_rr #(.ANCHO(4)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .Valido(Valido), .Listo(Listo),
        .X(X), .Selector(Selector),
        .ValidoX(ValidoX), .ListoX(ListoX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ex, input logic [2:0] es,
                           input logic ev);
        chk({tag, ".X"}, 8'(X), 8'(ex));
        chk({tag, ".Selector"}, 8'(Selector), 8'(es));
        chk({tag, ".ValidoX"}, 8'(ValidoX), 8'(ev));
    endtask

    initial begin
        rst = 1'b1; Valido = 4'hF; ListoX = 1'b0;
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;

        // 1. reset with every channel requesting
        #1;
        chk("rst.Listo0", 8'(Listo), 8'h0);
        tick();
        chk("rst.Listo1", 8'(Listo), 8'h0);
        chk_out("rst.c1", 4'h0, 3'b000, 1'b0);
        tick();
        rst = 1'b0; Valido = 4'h0;
        #1;
        chk("rel.Listo", 8'(Listo), 8'h0);
        chk_out("rel", 4'h0, 3'b000, 1'b0);

        // 2. single channel B
        B = 4'hA; Valido = 4'b0010; ListoX = 1'b1;
        #1;
        chk("single.Listo", 8'(Listo), 8'b0010);
        tick();
        Valido = 4'h0;
        chk_out("single.out", 4'hA, 3'b010, 1'b1);
        tick();
        chk("single.drain", 8'(ValidoX), 8'h0);

        // 3. fairness from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
        Valido = 4'hF; ListoX = 1'b1;
        #1;
        chk("rr.Listo0", 8'(Listo), 8'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 4'((i % 4) + 1), 3'((i % 4) + 1), 1'b1);
        end

        // 4. backpressure while A waits
        Valido = 4'b0100; C = 4'h5;
        #1;
        chk("bp.grantC", 8'(Listo), 8'b0100);
        tick();
        chk_out("bp.held", 4'h5, 3'b011, 1'b1);
        Valido = 4'b0001; A = 4'h7; ListoX = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.Listo", i), 8'(Listo), 8'h0);
            tick();
            chk_out($sformatf("bp%0d", i), 4'h5, 3'b011, 1'b1);
        end
        ListoX = 1'b1;
        #1;
        chk("bp.release.Listo", 8'(Listo), 8'b0001);
        tick();
        Valido = 4'h0;
        chk_out("bp.A", 4'h7, 3'b001, 1'b1);

        // 5. drain and capture D in one cycle
        D = 4'h9; Valido = 4'b1000;
        #1;
        chk("dc.Listo", 8'(Listo), 8'b1000);
        tick();
        Valido = 4'h0;
        chk_out("dc.D", 4'h9, 3'b100, 1'b1);

        // 6. reset while holding a word under backpressure
        ListoX = 1'b0;
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
        rst = 1'b1; Valido = 4'hF;
        #1;
        chk("mrst.Listo", 8'(Listo), 8'h0);
        tick();
        rst = 1'b0;
        chk_out("mrst.out", 4'h0, 3'b000, 1'b0);
        #1;
        chk("mrst.grantA", 8'(Listo), 8'b0001);
        tick();
        chk_out("mrst.A", 4'h1, 3'b001, 1'b1);

        // lone requester is granted back to back
        ListoX = 1'b1; Valido = 4'b0010;
        tick();
        chk_out("lone0", 4'h2, 3'b010, 1'b1);
        #1;
        chk("lone.Listo", 8'(Listo), 8'b0010);
        tick();
        chk_out("lone1", 4'h2, 3'b010, 1'b1);
        Valido = 4'h0;
        tick();
        chk("lone.drain", 8'(ValidoX), 8'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multiplexor_4a1_rr.md
# multiplexor_4a1_rr

- Collects 4-bit words from four source channels A, B, C, D onto one output channel X, performing the inverse of the 1-to-4 demultiplexor.
- Tags each output word with the 3-bit Selector code of its source channel, using the demultiplexor's encoding, so a downstream demultiplexor can route it back.
- Arbitrates between channels round-robin and holds each word in a single-entry output register.
- Every channel, input and output, uses a valid/ready handshake.

## Interface
Parameters:
- ANCHO, default 4: data width of every channel.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- A, B, C, D, input, ANCHO each: source channel data.
- Valido, input, 4: request per channel; bit0 = A, bit1 = B, bit2 = C, bit3 = D.
- Listo, output, 4: accept per channel, same bit order.
- X, output, ANCHO: output data, registered.
- Selector, output, 3: source tag, registered. Codes: 001 = A, 010 = B, 011 = C, 100 = D, 000 = none.
- ValidoX, output, 1: X and Selector hold a word.
- ListoX, input, 1: downstream accepts the word.

## Operation
State machine, two states:
- VACIO: no word held.
  - ValidoX = 0.
  - Any request is granted and captured; next state is LLENO.
- LLENO: word held.
  - ValidoX = 1.
  - If ListoX = 1 and a request is pending: drain and capture in the same cycle; stay in LLENO.
  - If ListoX = 1 and no request: go to VACIO.
  - If ListoX = 0: stay in LLENO; X and Selector hold, and Listo = 0000.

Capture condition: puede = (estado == VACIO) || ListoX.

Round-robin pointer Ultimo (2 bits):
- Records the last granted channel.
- Priority order starts at Ultimo+1 and wraps modulo 4; it wraps from D (3) back to A (0).
- On reset, Ultimo = 3, so A has first priority.
- Updated only on a capture.

Grant and capture:
- Listo is combinational and one-hot or zero.
- Listo[i] = 1 only for the highest-priority requesting channel, and only when puede = 1 and rst = 0.
- A transfer on channel i happens when Valido[i] && Listo[i]. In that cycle:
  - X takes the channel's data.
  - Selector takes the channel's code.
  - Ultimo takes i.

Sources must hold Valido and the data stable until Listo. Behaviour when a source drops its request early is undefined.

While ValidoX = 1 and ListoX = 0, X, Selector and ValidoX must not change.

Reset values:
- estado = VACIO, ValidoX = 0, X = 0, Selector = 000, Ultimo = 3.
- Listo = 0000 while rst is high.

Reset in the middle of a transfer:
- The held word is discarded.
- No input is accepted in the reset cycle.

## Timing
- Latency: a word accepted in cycle N appears on X with ValidoX = 1 in cycle N+1.
- Throughput: with ListoX held at 1, one word per cycle and no bubbles.
- Grant path: Valido and ListoX to Listo is combinational. The data path is registered.
- Concurrent requests: all four channels requesting continuously with ListoX = 1 produce the Selector sequence 001, 010, 011, 100, 001, … One channel can never be granted twice in a row while another is requesting.
- A lone requester is granted every cycle.
- ListoX = 1 while in VACIO has no effect.

## Test plan
1. Reset: assert rst for 2 cycles with all Valido = 1.
   - Required during reset and in the first cycle after release: Listo = 0000, ValidoX = 0, X = 0, Selector = 000.
2. Single channel: B = 4'hA, Valido = 0010, ListoX = 1, for one cycle.
   - Same cycle: Listo = 0010.
   - Next cycle: X = 4'hA, Selector = 010, ValidoX = 1.
   - Cycle after that: ValidoX = 0.
3. Fairness: A, B, C, D = 1, 2, 3, 4, all Valido held, ListoX = 1, for 8 cycles.
   - Selector sequence: 001, 010, 011, 100, 001, 010, 011, 100.
   - X sequence: 1, 2, 3, 4, 1, 2, 3, 4.
4. Backpressure: hold a word with C = 4'h5, then drive ListoX = 0 for 3 cycles with A requesting.
   - X = 5 and Selector = 011 stay stable.
   - Listo = 0000.
   - On the first cycle with ListoX = 1, A is accepted; it appears on X one cycle later with Selector = 001.
5. Drain and capture together: in LLENO with ListoX = 1 and D requesting.
   - Listo = 1000 in the same cycle.
   - ValidoX stays 1 with no gap; next X is D's data with Selector = 100.
6. Reset in the middle of a transfer: in LLENO with ListoX = 0, pulse rst for one cycle.
   - Next cycle: ValidoX = 0 and Selector = 000.
   - With all four channels requesting, the next grant goes to A.
